// File: rtl/dsp_pkg.sv
// Shared definitions for the dedicated sum processor.
//
// Contents:
//   state_e  - control FSM states, S_IDLE .. S_OUT
//   wsel_e   - register-file write-data select (adder sum or constant one)
//   REG_I    - register index holding the loop counter i
//   REG_S    - register index holding the running sum
//   REG_ONE  - register index holding the increment constant 1
//
// Build option: DSP_SATURATE_EN (see dedicated_sum_proc.sv) does not change this package.

package dsp_pkg;

   // Control states, one register-file write at most per state.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR_I = 3'd1,
      S_CLR_S = 3'd2,
      S_SET1  = 3'd3,
      S_CMP   = 3'd4,
      S_INC   = 3'd5,
      S_ACC   = 3'd6,
      S_OUT   = 3'd7
   } state_e;

   // Write-data mux select.
   typedef enum logic {
      WSEL_SUM = 1'b0,
      WSEL_ONE = 1'b1
   } wsel_e;

   // Register map. R0 is the hardwired zero register.
   localparam int REG_I   = 1;
   localparam int REG_S   = 2;
   localparam int REG_ONE = 3;

endpackage

// File: rtl/dsp_regfile.sv
// Register file for the dedicated sum processor.
//
// NUM_REGS x DATA_W storage with two asynchronous read ports and one
// synchronous write port. R0 always reads as zero and writes to it are
// dropped, so R0+R0 can be used to clear any other register. The storage
// is deliberately not reset: the control sequence initialises every
// register it reads before using it.
//
// Ports:
//   clk     in   1       write clock
//   we      in   1       write enable
//   waddr   in   ADDR_W  write address
//   wdata   in   DATA_W  write data
//   raddr1  in   ADDR_W  read port 1 address
//   rdata1  out  DATA_W  read port 1 data (combinational)
//   raddr2  in   ADDR_W  read port 2 address
//   rdata2  out  DATA_W  read port 2 data (combinational)

module dsp_regfile
   import dsp_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 8,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Single write port; the R0 slot is never written so it cannot
   // shadow the hardwired zero.
   always_ff @(posedge clk) begin
      if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Both read ports return zero for address 0 regardless of storage.
   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/dedicated_sum_proc.sv
// Dedicated processor computing result = 1 + 2 + ... + limit.
//
// A start pulse in idle captures limit; the FSM then clears i and sum,
// loads the constant one, and loops compare / increment / accumulate
// through the register file until i reaches the captured limit. The sum
// is then copied to the registered result port together with a one-cycle
// done pulse. ovf reports that the sum carried out of DATA_W bits at some
// point during that run.
//
// Build option:
//   DSP_SATURATE_EN  defined: an accumulate that carries out writes all
//                    ones, so the sum sticks at the maximum value.
//                    undefined: the sum wraps modulo 2**DATA_W.
//                    ovf is set on any carry-out in both builds.
//
// Ports:
//   clk     in   1       clock, all state on the rising edge
//   rst     in   1       synchronous active-low reset
//   start   in   1       run request, accepted only while idle
//   limit   in   DATA_W  N, captured on the accepting edge
//   busy    out  1       high whenever the FSM is not idle
//   done    out  1       one-cycle pulse when result/ovf are updated
//   result  out  DATA_W  last computed sum, held until the next done
//   ovf     out  1       sum exceeded 2**DATA_W-1 during the last run

module dedicated_sum_proc
   import dsp_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] limit,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              ovf
);

   localparam int ADDR_W = $clog2(NUM_REGS);

   localparam logic [ADDR_W-1:0] A_ZERO = '0;
   localparam logic [ADDR_W-1:0] A_I    = ADDR_W'(REG_I);
   localparam logic [ADDR_W-1:0] A_S    = ADDR_W'(REG_S);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(REG_ONE);

   state_e state_q, state_d;

   logic [DATA_W-1:0] lim_q;
   logic              ovf_q;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [ADDR_W-1:0] rf_raddr1;
   logic [ADDR_W-1:0] rf_raddr2;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   wsel_e             wsel;

   logic              accept;
   logic              acc_chk;
   logic              out_load;

   logic [DATA_W-1:0] add_sum;
   logic              add_carry;
   logic [DATA_W-1:0] sum_wdata;
   logic              lt;

   dsp_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (rf_raddr1),
      .rdata1 (rdata1),
      .raddr2 (rf_raddr2),
      .rdata2 (rdata2)
   );

   // Shared adder; the extra top bit is the carry-out used for overflow.
   assign {add_carry, add_sum} = {1'b0, rdata1} + {1'b0, rdata2};

   // Once the sum has saturated, adding i>0 always carries again,
   // so the all-ones value sticks for the rest of the run.
`ifdef DSP_SATURATE_EN
   assign sum_wdata = add_carry ? '1 : add_sum;
`else
   assign sum_wdata = add_sum;
`endif

   assign rf_wdata = (wsel == WSEL_ONE) ? DATA_W'(1) : sum_wdata;

   // Unsigned loop test; i never wraps because it stays below lim_q.
   assign lt = (rdata1 < lim_q);

   assign busy = (state_q != S_IDLE);

   // State register; reset aborts any run immediately.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fixed setup sequence, then a three-state loop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CLR_I;
         S_CLR_I: state_d = S_CLR_S;
         S_CLR_S: state_d = S_SET1;
         S_SET1:  state_d = S_CMP;
         S_CMP:   state_d = lt ? S_INC : S_OUT;
         S_INC:   state_d = S_ACC;
         S_ACC:   state_d = S_CMP;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: register-file addressing, write control and the
   // strobes that drive the result/overflow registers below.
   always_comb begin
      rf_we     = 1'b0;
      rf_waddr  = A_ZERO;
      rf_raddr1 = A_ZERO;
      rf_raddr2 = A_ZERO;
      wsel      = WSEL_SUM;
      accept    = 1'b0;
      acc_chk   = 1'b0;
      out_load  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            accept = start;
         end
         S_CLR_I: begin
            rf_we    = 1'b1;
            rf_waddr = A_I;
         end
         S_CLR_S: begin
            rf_we    = 1'b1;
            rf_waddr = A_S;
         end
         S_SET1: begin
            rf_we    = 1'b1;
            rf_waddr = A_ONE;
            wsel     = WSEL_ONE;
         end
         S_CMP: begin
            rf_raddr1 = A_I;
         end
         S_INC: begin
            rf_we     = 1'b1;
            rf_waddr  = A_I;
            rf_raddr1 = A_I;
            rf_raddr2 = A_ONE;
         end
         S_ACC: begin
            rf_we     = 1'b1;
            rf_waddr  = A_S;
            rf_raddr1 = A_S;
            rf_raddr2 = A_I;
            acc_chk   = 1'b1;
         end
         S_OUT: begin
            rf_raddr1 = A_S;
            out_load  = 1'b1;
         end
         default: begin
            rf_we = 1'b0;
         end
      endcase
   end

   // Limit capture, sticky overflow tracking and the registered outputs.
   // done defaults low so it can only ever be a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lim_q  <= '0;
         ovf_q  <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            lim_q <= limit;
            ovf_q <= 1'b0;
         end
         if (acc_chk && add_carry) begin
            ovf_q <= 1'b1;
         end
         if (out_load) begin
            result <= rdata1;
            ovf    <= ovf_q;
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dedicated_sum_proc.sv
// Self-checking bench for dedicated_sum_proc (default parameters, DATA_W=8).
// Expected sums, overflow flags and done-edge numbers are pushed into a
// scoreboard queue when a run is issued; a monitor pops and compares every
// time the DUT pulses done. Honours DSP_SATURATE_EN for the overflow case.

module tb_dedicated_sum_proc;

   typedef struct {
      logic [7:0] result;
      logic       ovf;
      int         cycle;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] limit;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       ovf;

   exp_t sb[$];
   int   cyc;
   int   total;
   int   bad;

   dedicated_sum_proc dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .limit  (limit),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ovf    (ovf)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges so expected done timing can be stated as an edge number.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Global safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   // Single place where comparisons are counted and reported.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: sum 1..n in 8 bits with wrap or saturation.
   function automatic exp_t model(input int n);
      exp_t e;
      int   s;
      s     = 0;
      e.ovf = 1'b0;
      for (int i = 1; i <= n; i++) begin
         s = s + i;
         if (s > 255) begin
            e.ovf = 1'b1;
`ifdef DSP_SATURATE_EN
            s = 255;
`else
            s = s - 256;
`endif
         end
      end
      e.result = 8'(s);
      e.cycle  = 0;
      return e;
   endfunction

   // Issues a start with the given limit on the next edge and records the
   // expectation. With hold set, start is left high after the accepting edge.
   task automatic applyStimulus(input int lim, input bit hold, output int acceptEdge);
      exp_t e;
      @(negedge clk);
      start      = 1'b1;
      limit      = 8'(lim);
      acceptEdge = cyc + 1;
      e          = model(lim);
      e.cycle    = acceptEdge + 3 * lim + 5;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Waits for every outstanding expectation to be consumed, bounded.
   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every done pulse must match the oldest expectation in value and timing.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done actual=1 expected=0 (edge %0d result=%0d)", cyc, result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", 32'(result), 32'(e.result));
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            checkOutput("done_edge", 32'(cyc), 32'(e.cycle));
         end
      end
   end

   // Directed test sequence.
   initial begin
      int e0;
      int e1;
      int n;
      exp_t e;
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      start = 1'b0;
      limit = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b1;

      // limit=0: five busy cycles, result 0.
      $display("[TB] limit=0 run");
      applyStimulus(0, 1'b0, e0);
      n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      checkOutput("busy_cycles_n0", 32'(n), 32'd5);
      waitDone("n0");

      // limit=10: 55, and the result holds afterwards.
      $display("[TB] limit=10 run");
      applyStimulus(10, 1'b0, e0);
      waitDone("n10");
      repeat (6) @(negedge clk);
      checkOutput("result_hold", 32'(result), 32'd55);
      checkOutput("done_low_idle", 32'(done), 32'd0);

      // Largest non-overflowing run, then the first overflowing one, then recovery.
      $display("[TB] overflow boundary");
      applyStimulus(22, 1'b0, e0);
      waitDone("n22");
      applyStimulus(23, 1'b0, e0);
      waitDone("n23");
      applyStimulus(3, 1'b0, e0);
      waitDone("n3_after_ovf");

      // start/limit changes while busy are ignored.
      $display("[TB] start while busy");
      applyStimulus(5, 1'b0, e0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      limit = 8'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busy_mid_run", 32'(busy), 32'd1);
      waitDone("repulse");
      checkOutput("repulse_edge", 32'(cyc) >= 32'(e0 + 20) ? 32'd1 : 32'd0, 32'd1);

      // start held high through the done cycle: second run follows back-to-back.
      $display("[TB] back-to-back");
      applyStimulus(3, 1'b1, e0);
      while (cyc < e0 + 14) @(negedge clk);
      checkOutput("b2b_done_cycle", 32'(done), 32'd1);
      limit    = 8'd4;
      e1       = e0 + 15;
      e        = model(4);
      e.cycle  = e1 + 17;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("b2b");

      // Reset mid-run aborts with no done pulse and cleared outputs.
      $display("[TB] reset abort");
      applyStimulus(10, 1'b0, e0);
      while (cyc < e0 + 11) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_ovf", 32'(ovf), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      applyStimulus(4, 1'b0, e0);
      waitDone("after_abort");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
